// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Brief    : Shared types and constants for the two-slave APB subsystem.
// Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int APB_ADDR_W  = 8;
    localparam int APB_DATA_W  = 8;
    localparam int REQ_ADDR_W  = 7;
    localparam int SLV_SEL_BIT = 6;
    localparam int WAIT_CNT_W  = 8;

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : apb_wait_timer
// Brief    : Saturating ACCESS wait counter with terminal-count compare.
// Revision : 1.0 - initial release
// ============================================================================
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    localparam logic [WAIT_CNT_W-1:0] c_TERMINAL = WAIT_CNT_W'(TIMEOUT - 1);
    localparam logic [WAIT_CNT_W-1:0] c_MAX      = '1;

    logic [WAIT_CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == c_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Brief    : valid/ready request to two-phase APB transfer bridge, 2 slaves.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [REQ_ADDR_W-1:0] req_addr,
    input  logic [APB_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL1,
    output logic                  PSEL2,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [APB_ADDR_W-1:0] PADDR,
    output logic [APB_DATA_W-1:0] PWDATA,
    input  logic                  PREADY1,
    input  logic                  PREADY2,
    input  logic [APB_DATA_W-1:0] PRDATA1,
    input  logic [APB_DATA_W-1:0] PRDATA2
);

    localparam int c_PAD_W = APB_ADDR_W - SLV_SEL_BIT;

    apb_state_t            r_state;
    apb_state_t            w_state_nxt;
    logic                  r_slv;
    logic                  w_sel_ready;
    logic [APB_DATA_W-1:0] w_sel_rdata;
    logic                  w_expired;
    logic                  w_done;
    logic                  w_accept;

    assign w_sel_ready = r_slv ? PREADY2 : PREADY1;
    assign w_sel_rdata = r_slv ? PRDATA2 : PRDATA1;
    assign w_done      = (r_state == ACCESS) && (w_sel_ready || w_expired);
    assign req_ready   = (r_state == IDLE) || w_done;
    assign w_accept    = req_valid && req_ready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (PCLK),
        .rst       (PRESET),
        .i_clear   (r_state != ACCESS),
        .i_inc     ((r_state == ACCESS) && !w_done),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS:  if (w_done) w_state_nxt = w_accept ? SETUP : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The APB address/data/direction registers double as the request latch,
    // so they naturally hold their last values while idle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_slv     <= 1'b0;
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= w_done;
            rsp_err   <= w_done && !w_sel_ready;
            rsp_rdata <= (w_done && w_sel_ready && !PWRITE) ? w_sel_rdata : '0;
            if (w_accept) begin
                r_slv   <= req_addr[SLV_SEL_BIT];
                PSEL1   <= !req_addr[SLV_SEL_BIT];
                PSEL2   <= req_addr[SLV_SEL_BIT];
                PENABLE <= 1'b0;
                PWRITE  <= req_write;
                PADDR   <= {{c_PAD_W{1'b0}}, req_addr[SLV_SEL_BIT-1:0]};
                PWDATA  <= req_wdata;
            end else if (r_state == SETUP) begin
                PENABLE <= 1'b1;
            end else if (w_done) begin
                PSEL1   <= 1'b0;
                PSEL2   <= 1'b0;
                PENABLE <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
